// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: evaluates one LogicNets layer through a single shared
// 6-input LUT read path, one neuron per cycle. Truth tables and fan-in maps
// are loaded at run time while the block is idle.
module lut_layer_sequencer #(
    parameter int IN_BITS = 64,
    parameter int NEURONS = 16,
    parameter int IDX_W   = $clog2(IN_BITS),
    parameter int NW      = $clog2(NEURONS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [NW-1:0]      cfg_neuron,
    input  logic [63:0]        cfg_data,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_BITS-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NEURONS-1:0] out_data,
    output logic               busy
);

    localparam int MAP_W = 6 * IDX_W;
    localparam logic [IDX_W:0]  INB  = (IDX_W+1)'(IN_BITS);
    localparam logic [NW:0]     NB   = (NW+1)'(NEURONS);
    localparam logic [NW-1:0]   LAST = NW'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             state, state_nx;
    logic [NW-1:0]      cnt;
    logic [IN_BITS-1:0] in_reg;
    logic [NEURONS-1:0] res;
    logic [63:0]        tt  [NEURONS];
    logic [MAP_W-1:0]   map [NEURONS];

    logic               accept;
    logic               cfg_wr;
    logic [MAP_W-1:0]   map_cur;
    logic [IDX_W-1:0]   fld;
    logic [5:0]         addr;
    logic               tt_bit;

    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == IDLE) && !cfg_we;
    assign out_valid = (state == DONE);
    assign out_data  = res;
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign cfg_wr    = cfg_we && (state == IDLE) && ({1'b0, cfg_neuron} < NB);

    // State register; reset aborts any evaluation and drops out_valid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: accept -> sweep all neurons -> hold result until taken.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EVAL;
            EVAL:    if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shared LUT read path: gather six fan-in bits for the current neuron,
    // out-of-range indices read as 0.
    always_comb begin
        fld     = '0;
        addr    = '0;
        map_cur = map[cnt];
        for (int unsigned j = 0; j < 6; j++) begin
            fld     = map_cur[j*IDX_W +: IDX_W];
            addr[j] = ({1'b0, fld} < INB) ? in_reg[fld] : 1'b0;
        end
        tt_bit = tt[cnt][addr];
    end

    // Datapath: config writes and input latch in IDLE, one result bit per EVAL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            in_reg <= '0;
            res    <= '0;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                tt[i]  <= '0;
                map[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_wr) begin
                        if (cfg_sel) map[cfg_neuron] <= cfg_data[MAP_W-1:0];
                        else         tt[cfg_neuron]  <= cfg_data;
                    end
                    if (accept) begin
                        in_reg <= in_data;
                        cnt    <= '0;
                    end
                end
                EVAL: begin
                    res[cnt] <= tt_bit;
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Scoreboard bench for lut_layer_sequencer: expected layer outputs are queued
// when a vector is accepted; a monitor pops and compares on each output handshake.
module tb_lut_layer_sequencer;

    localparam int IN_BITS = 64;
    localparam int N       = 12;
    localparam int IDX_W   = 6;
    localparam int NW      = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we, cfg_sel;
    logic [NW-1:0]      cfg_neuron;
    logic [63:0]        cfg_data;
    logic               cfg_ready;
    logic               in_valid, in_ready;
    logic [IN_BITS-1:0] in_data;
    logic               out_valid, out_ready;
    logic [N-1:0]       out_data;
    logic               busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [N-1:0] q[$];

    lut_layer_sequencer #(.IN_BITS(IN_BITS), .NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_neuron(cfg_neuron),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_map(input int s0, input int s1, input int s2,
                                          input int s3, input int s4, input int s5);
        logic [63:0] m;
        m = '0;
        m[0*IDX_W +: IDX_W] = IDX_W'(s0);
        m[1*IDX_W +: IDX_W] = IDX_W'(s1);
        m[2*IDX_W +: IDX_W] = IDX_W'(s2);
        m[3*IDX_W +: IDX_W] = IDX_W'(s3);
        m[4*IDX_W +: IDX_W] = IDX_W'(s4);
        m[5*IDX_W +: IDX_W] = IDX_W'(s5);
        return m;
    endfunction

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                check("out_data", 64'(out_data), 64'(q.pop_front()));
            end
        end
    end

    // Called just after a rising edge; write lands on the next edge.
    task automatic cfg_write(input logic sel, input logic [NW-1:0] n, input logic [63:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_neuron = n; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [IN_BITS-1:0] v, input logic [N-1:0] exp,
                        input bit bp, input bit inject, input bit abort);
        int unsigned k;
        bit ok;
        logic [N-1:0] hold;
        k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        check("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1; in_data = v;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        check("busy_after_accept", busy, 1);
        if (abort) begin
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            return;
        end
        q.push_back(exp);
        ok = 0;
        for (k = 1; k <= 4*N && !ok; k++) begin
            if (inject && k == 2) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 4'd4; cfg_data = '1;
                #1;
                check("eval_cfg_ready", cfg_ready, 0);
                check("eval_in_ready", in_ready, 0);
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (out_valid) begin
                ok = 1;
                check("latency", k, N);
            end
        end
        if (!ok) check("out_valid_timeout", 0, 1);
        if (!bp) begin
            @(posedge clk); #1;
            check("valid_pulse", out_valid, 0);
            check("in_ready_after", in_ready, 1);
        end else begin
            hold = out_data;
            repeat (10) begin
                @(posedge clk); #1;
                check("bp_valid", out_valid, 1);
                check("bp_data", 64'(out_data), 64'(hold));
                check("bp_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("bp_release_valid", out_valid, 0);
            check("bp_release_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_neuron = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Empty tables give all-zero outputs.
        send('1, 12'h000, 0, 0, 0);

        // n0 = AND of in[5:0]; n1 = parity of in[5:0]; n2 = in[40]; n11 = const 1.
        cfg_write(1'b0, 4'd0, 64'h8000_0000_0000_0000);
        cfg_write(1'b1, 4'd0, mk_map(0, 1, 2, 3, 4, 5));
        cfg_write(1'b0, 4'd1, 64'h6996_9669_9669_6996);
        cfg_write(1'b1, 4'd1, mk_map(5, 4, 3, 2, 1, 0));
        cfg_write(1'b0, 4'd2, 64'hAAAA_AAAA_AAAA_AAAA);
        cfg_write(1'b1, 4'd2, mk_map(40, 0, 0, 0, 0, 0));
        cfg_write(1'b0, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF);

        send(64'h3F, 12'h801, 0, 0, 0);
        send(64'h1F, 12'h802, 0, 0, 0);
        send((64'h1 << 40) | 64'h3F, 12'h805, 0, 0, 0);

        // Config write collides with in_valid: write wins, no accept.
        in_valid = 1'b1; in_data = 64'h3F;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 4'd3; cfg_data = '1;
        #1;
        check("collide_in_ready", in_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0; in_data = '0;
        check("collide_busy", busy, 0);
        send(64'h0, 12'h808, 0, 0, 0);

        // Write attempted during EVAL is dropped.
        send(64'h0, 12'h808, 0, 1, 0);
        send(64'h0, 12'h808, 0, 0, 0);

        // Out-of-range neuron selects write nothing.
        cfg_write(1'b0, 4'd12, '1);
        cfg_write(1'b0, 4'd15, '1);
        cfg_write(1'b1, 4'd12, '1);
        send(64'h0, 12'h808, 0, 0, 0);

        // Back-pressure.
        out_ready = 1'b0;
        send(64'h1F, 12'h80A, 1, 0, 0);

        // Reset mid-EVAL, then tables must read as cleared.
        send(64'h3F, 12'h000, 0, 0, 1);
        @(posedge clk); #1;
        send('1, 12'h000, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
